// File: rtl/fp32_result_packer_pkg.sv
// Shared constants and types for the binary32 result packer.
package fp32_result_packer_pkg;

   localparam int unsigned MANT_W = 48;
   localparam int unsigned NORM_W = 47;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned EXPF_W = 8;
   localparam int unsigned LZC_W  = 6;
   localparam int unsigned SH_W   = 5;
   localparam int unsigned SH_MAX = 26;

   localparam logic [EXPF_W-1:0] EXP_ALL1 = 8'hFF;
   localparam int unsigned       EXP_BIAS = 127;

   localparam int unsigned FLG_INVALID   = 3;
   localparam int unsigned FLG_OVERFLOW  = 2;
   localparam int unsigned FLG_UNDERFLOW = 1;
   localparam int unsigned FLG_INEXACT   = 0;

   typedef enum logic [1:0] {
      CLS_FIN  = 2'd0,
      CLS_NAN  = 2'd1,
      CLS_INF  = 2'd2,
      CLS_ZERO = 2'd3
   } cls_e;

   // Stage-1 payload; n holds the bits below the (implicit) leading one.
   typedef struct packed {
      cls_e              cls;
      logic              sign;
      logic              invalid;
      logic              tiny;
      logic              sticky;
      logic [NORM_W-1:0] n;
   } s1_t;

   function automatic logic [31:0] fp32_inf(input logic s);
      return {s, EXP_ALL1, FRAC_W'(0)};
   endfunction

   function automatic logic [31:0] fp32_zero(input logic s);
      return {s, 31'h0};
   endfunction

endpackage

// File: rtl/fp32_result_packer_lzc48.sv
// Combinational 48-bit leading-zero counter with all-zero flag.
module lzc48
   import fp32_result_packer_pkg::*;
(
   input  logic [MANT_W-1:0] i_vec,
   output logic [LZC_W-1:0]  o_cnt,
   output logic              o_zero
);

   // Scan upward so the highest set bit wins.
   always_comb begin
      o_cnt  = LZC_W'(MANT_W);
      o_zero = 1'b1;
      for (int i = 0; i < int'(MANT_W); i++) begin
         if (i_vec[i]) begin
            o_cnt  = LZC_W'(int'(MANT_W) - 1 - i);
            o_zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/fp32_result_packer.sv
// Final FP multiplier stage: normalise, round-to-nearest-even and pack a binary32
// result from special-case flags, sign, biased exponent and 48-bit significand product.
module fp32_result_packer
   import fp32_result_packer_pkg::*;
#(
   parameter int unsigned EXP_W = 10,
   parameter logic [31:0] QNAN  = 32'h7FC00000,
   parameter bit          FTZ   = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sign,
   input  logic               in_nan,
   input  logic               in_inf,
   input  logic               in_zero,
   input  logic               in_invalid,
   input  logic [EXP_W-1:0]   in_exp,
   input  logic [MANT_W-1:0]  in_mant,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_result,
   output logic [3:0]         out_flags
);

   localparam int unsigned EW = EXP_W + 2;

   logic              r_s1_v;
   s1_t               r_s1;
   logic [EW-1:0]     r_e;
   logic              r_s2_v;
   logic [31:0]       r_result;
   logic [3:0]        r_flags;

   logic              w_en1;
   logic              w_en2;
   logic [LZC_W-1:0]  w_lzc;
   logic              w_mzero;
   logic [MANT_W-1:0] w_norm;
   logic [EW-1:0]     w_e_raw;
   logic [EW-1:0]     w_ome;
   logic              w_tiny;
   logic [SH_W-1:0]   w_sh;
   logic [MANT_W-1:0] w_mask;
   logic              w_sticky;
   logic [NORM_W-1:0] w_n_den;
   cls_e              w_cls;

   logic [FRAC_W-1:0] w_frac;
   logic              w_g;
   logic              w_s;
   logic              w_inc;
   logic [30:0]       w_sum;
   logic              w_inexact;
   logic              w_ovf;
   logic [31:0]       w_result;
   logic [3:0]        w_flags;

   // Elastic two-entry pipeline: each stage advances when the one after it can take data.
   assign w_en2     = !r_s2_v || out_ready;
   assign w_en1     = !r_s1_v || w_en2;
   assign in_ready  = w_en1;
   assign out_valid = r_s2_v;
   assign out_result = r_result;
   assign out_flags  = r_flags;

   lzc48 u_lzc (
      .i_vec  (in_mant),
      .o_cnt  (w_lzc),
      .o_zero (w_mzero)
   );

   // Stage 1: e = in_exp + p - 46 with p = 47 - lzc; tiny results are pre-shifted to denormal.
   always_comb begin
      w_norm   = in_mant << w_lzc;
      w_e_raw  = {{(EW-EXP_W){in_exp[EXP_W-1]}}, in_exp} + EW'(1) - EW'(w_lzc);
      w_tiny   = w_e_raw[EW-1] || (w_e_raw == '0);
      w_ome    = EW'(1) - w_e_raw;
      w_sh     = (w_ome > EW'(SH_MAX)) ? SH_W'(SH_MAX) : w_ome[SH_W-1:0];
      w_mask   = (MANT_W'(1) << w_sh) - MANT_W'(1);
      w_sticky = |(w_norm & w_mask);
      w_n_den  = NORM_W'(w_norm >> w_sh);
      if (in_nan || in_invalid)   w_cls = CLS_NAN;
      else if (in_inf)            w_cls = CLS_INF;
      else if (in_zero || w_mzero) w_cls = CLS_ZERO;
      else                        w_cls = CLS_FIN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_v <= 1'b0;
         r_s1   <= '0;
         r_e    <= '0;
      end else if (w_en1) begin
         r_s1_v <= in_valid;
         if (in_valid) begin
            r_s1.cls     <= w_cls;
            r_s1.sign    <= in_sign;
            r_s1.invalid <= in_invalid;
            r_s1.tiny    <= w_tiny;
            r_s1.sticky  <= w_tiny ? w_sticky : 1'b0;
            r_s1.n       <= w_tiny ? w_n_den : w_norm[NORM_W-1:0];
            r_e          <= w_tiny ? '0 : w_e_raw;
         end
      end
   end

   // Stage 2: round to nearest-even; the 31-bit add lets a fraction carry bump the exponent.
   always_comb begin
      w_frac    = r_s1.n[NORM_W-1:FRAC_W+1];
      w_g       = r_s1.n[FRAC_W];
      w_s       = (|r_s1.n[FRAC_W-1:0]) | r_s1.sticky;
      w_inc     = w_g & (w_s | w_frac[0]);
      w_sum     = {r_e[EXPF_W-1:0], w_frac} + 31'(w_inc);
      w_inexact = w_g | w_s;
      w_ovf     = (!r_e[EW-1] && (r_e >= EW'(255))) || (w_sum[30:23] == EXP_ALL1);
      w_result  = '0;
      w_flags   = '0;
      unique case (r_s1.cls)
         CLS_NAN: begin
            w_result             = QNAN;
            w_flags[FLG_INVALID] = r_s1.invalid;
         end
         CLS_INF:  w_result = fp32_inf(r_s1.sign);
         CLS_ZERO: w_result = fp32_zero(r_s1.sign);
         default: begin
            if (w_ovf) begin
               w_result              = fp32_inf(r_s1.sign);
               w_flags[FLG_OVERFLOW] = 1'b1;
               w_flags[FLG_INEXACT]  = 1'b1;
            end else if (FTZ && r_s1.tiny) begin
               w_result               = fp32_zero(r_s1.sign);
               w_flags[FLG_UNDERFLOW] = 1'b1;
               w_flags[FLG_INEXACT]   = 1'b1;
            end else begin
               w_result               = {r_s1.sign, w_sum};
               w_flags[FLG_UNDERFLOW] = r_s1.tiny & w_inexact;
               w_flags[FLG_INEXACT]   = w_inexact;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_v   <= 1'b0;
         r_result <= '0;
         r_flags  <= '0;
      end else if (w_en2) begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_result <= w_result;
            r_flags  <= w_flags;
         end
      end
   end

endmodule

// File: tb/tb_fp32_result_packer.sv
// Self-checking bench for fp32_result_packer: directed corner cases plus a randomized
// stream scored against an exact-arithmetic binary32 rounding model.
module tb_fp32_result_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_sign, in_nan, in_inf, in_zero, in_invalid;
   logic [9:0]  in_exp;
   logic [47:0] in_mant;
   logic        out_ready;
   logic        in_ready, out_valid;
   logic [31:0] out_result;
   logic [3:0]  out_flags;
   logic        f_in_ready, f_out_valid;
   logic [31:0] f_result;
   logic [3:0]  f_flags;

   int n_tests = 0;
   int n_fail  = 0;
   int cur_exp = 0;

   always #5 clk = ~clk;

   fp32_result_packer #(.EXP_W(10), .QNAN(32'h7FC00000), .FTZ(1'b0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
      .in_invalid(in_invalid), .in_exp(in_exp), .in_mant(in_mant),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags));

   fp32_result_packer #(.EXP_W(10), .QNAN(32'h7FC00000), .FTZ(1'b1)) u_dut_ftz (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f_in_ready),
      .in_sign(in_sign), .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
      .in_invalid(in_invalid), .in_exp(in_exp), .in_mant(in_mant),
      .out_valid(f_out_valid), .out_ready(out_ready),
      .out_result(f_result), .out_flags(f_flags));

   // Exact value is mant * 2^(exp-173); quantise to the binary32 grid and round half-even.
   function automatic logic [35:0] model(input logic sgn, input logic nan, input logic inf,
                                         input logic zero, input logic inv, input int expv,
                                         input logic [47:0] mant, input bit ftz);
      int p, ebin, u, sh;
      bit tiny, inexact, up;
      logic [127:0] q, rem, half, m;
      longint bits;
      if (nan || inv) return {inv, 3'b000, 32'h7FC00000};
      if (inf) return {4'b0000, sgn, 8'hFF, 23'h0};
      if (zero || mant == 48'h0) return {4'b0000, sgn, 31'h0};
      p = 47;
      while (p > 0 && !mant[p]) p--;
      ebin = p + expv - 173;
      if (ebin + 127 >= 255) return {4'b0101, sgn, 8'hFF, 23'h0};
      tiny = (ebin < -126);
      u    = tiny ? -149 : ebin - 23;
      sh   = expv - 173 - u;
      m    = 128'(mant);
      if (sh >= 0) begin
         q = m << sh; inexact = 1'b0; up = 1'b0;
      end else if (-sh > 60) begin
         q = '0; inexact = 1'b1; up = 1'b0;
      end else begin
         q       = m >> (-sh);
         rem     = m - (q << (-sh));
         half    = 128'(1) << (-sh - 1);
         inexact = (rem != 0);
         up      = (rem > half) || (rem == half && q[0]);
      end
      q = q + 128'(up);
      if (q < 128'h800000) bits = longint'(q[63:0]);
      else bits = longint'(q[63:0]) + (longint'(u + 149) << 23);
      if (bits >= 64'h7F800000) return {4'b0101, sgn, 8'hFF, 23'h0};
      if (tiny && ftz) return {4'b0011, sgn, 31'h0};
      return {2'b00, tiny && inexact, inexact, sgn, bits[30:0]};
   endfunction

   task automatic drive(input logic sg, input logic nn, input logic nf, input logic nz,
                        input logic ni, input int ev, input logic [47:0] mt);
      in_sign = sg; in_nan = nn; in_inf = nf; in_zero = nz; in_invalid = ni;
      cur_exp = ev; in_exp = 10'(ev); in_mant = mt;
   endtask

   task automatic gen_beat();
      int r, sel;
      logic [47:0] mt;
      r  = int'($urandom_range(0, 99));
      mt = {16'($urandom), $urandom};
      if ($urandom_range(0, 9) < 7) begin
         if ($urandom_range(0, 1) == 1) mt[47] = 1'b1; else begin mt[47] = 1'b0; mt[46] = 1'b1; end
      end else begin
         mt = mt >> $urandom_range(0, 47);
      end
      sel = int'($urandom_range(0, 3));
      case (sel)
         0:       cur_exp = int'($urandom_range(100, 160));
         1:       cur_exp = int'($urandom_range(0, 60)) - 40;
         2:       cur_exp = int'($urandom_range(240, 300));
         default: cur_exp = int'($urandom_range(0, 1023)) - 512;
      endcase
      drive(1'($urandom), r < 4, r >= 10 && r < 14, r >= 14 && r < 18, r >= 4 && r < 8,
            cur_exp, (r >= 18 && r < 20) ? 48'h0 : mt);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 48'h0);
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b r=%h f=%b, want v=0 r=0 f=0", out_valid, out_result, out_flags);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b, want 1", in_ready);
      end
   endtask

   task automatic send_check(input string nm, input logic sg, input logic nn, input logic nf,
                             input logic nz, input logic ni, input int ev, input logic [47:0] mt,
                             input logic [31:0] xr, input logic [3:0] xf,
                             input logic [31:0] xr_f, input logic [3:0] xf_f);
      int k;
      out_ready = 1'b1;
      drive(sg, nn, nf, nz, ni, ev, mt);
      in_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s accept: in_ready=%b, want 1", nm, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s latency1: out_valid=%b, want 0", nm, out_valid); end
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s latency2: out_valid=%b, want 1", nm, out_valid); end
      n_tests++;
      if (out_result !== xr) begin n_fail++; $display("FAIL %s result: got %h, want %h", nm, out_result, xr); end
      n_tests++;
      if (out_flags !== xf) begin n_fail++; $display("FAIL %s flags: got %b, want %b", nm, out_flags, xf); end
      n_tests++;
      if (f_result !== xr_f || f_flags !== xf_f) begin
         n_fail++; $display("FAIL %s ftz: got %h/%b, want %h/%b", nm, f_result, f_flags, xr_f, xf_f);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      send_check("one",       0, 0, 0, 0, 0, 127, 48'h4000_0000_0000, 32'h3F800000, 4'b0000, 32'h3F800000, 4'b0000);
      send_check("1p5sq",     0, 0, 0, 0, 0, 127, 48'h9000_0000_0000, 32'h40100000, 4'b0000, 32'h40100000, 4'b0000);
      send_check("rne_tie_dn",0, 0, 0, 0, 0, 127, 48'h4000_0040_0000, 32'h3F800000, 4'b0001, 32'h3F800000, 4'b0001);
      send_check("rne_up",    0, 0, 0, 0, 0, 127, 48'h4000_00C0_0000, 32'h3F800002, 4'b0001, 32'h3F800002, 4'b0001);
      send_check("ovf_exp",   1, 0, 0, 0, 0, 300, 48'h4000_0000_0000, 32'hFF800000, 4'b0101, 32'hFF800000, 4'b0101);
      send_check("ovf_round", 0, 0, 0, 0, 0, 254, 48'h7FFF_FFFF_FFFF, 32'h7F800000, 4'b0101, 32'h7F800000, 4'b0101);
      send_check("denorm",    0, 0, 0, 0, 0,  -1, 48'h4000_0000_0000, 32'h00200000, 4'b0000, 32'h00000000, 4'b0011);
      send_check("den2norm",  0, 0, 0, 0, 0,   0, 48'h7FFF_FFFF_FFFF, 32'h00800000, 4'b0011, 32'h00000000, 4'b0011);
      send_check("nan",       0, 1, 0, 0, 0, 127, 48'h4000_0000_0000, 32'h7FC00000, 4'b0000, 32'h7FC00000, 4'b0000);
      send_check("invalid",   0, 0, 1, 1, 1, 127, 48'h0,              32'h7FC00000, 4'b1000, 32'h7FC00000, 4'b1000);
      send_check("neg_zero",  1, 0, 0, 1, 0, 127, 48'h4000_0000_0000, 32'h80000000, 4'b0000, 32'h80000000, 4'b0000);
      send_check("inf",       0, 0, 1, 0, 0,  50, 48'h4000_0000_0000, 32'h7F800000, 4'b0000, 32'h7F800000, 4'b0000);
      send_check("mant_zero", 1, 0, 0, 0, 0, 127, 48'h0,              32'h80000000, 4'b0000, 32'h80000000, 4'b0000);
   endtask

   task automatic test_random(input int nbeats);
      logic [71:0] sb[$];
      logic [71:0] x;
      int sent, got, cyc;
      bit acc;
      sent = 0; got = 0; cyc = 0;
      in_valid = 1'b0;
      while (got < nbeats && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         acc = in_valid && in_ready;
         if (acc) begin
            sb.push_back({model(in_sign, in_nan, in_inf, in_zero, in_invalid, cur_exp, in_mant, 1'b1),
                          model(in_sign, in_nan, in_inf, in_zero, in_invalid, cur_exp, in_mant, 1'b0)});
            sent++;
         end
         if (out_valid && out_ready) begin
            got++;
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++; $display("FAIL rand_extra: unexpected result %h", out_result);
            end else begin
               x = sb.pop_front();
               if ({out_flags, out_result} !== x[35:0]) begin
                  n_fail++; $display("FAIL rand_beat%0d: got %b/%h, want %b/%h", got, out_flags, out_result, x[35:32], x[31:0]);
               end
               n_tests++;
               if ({f_flags, f_result} !== x[71:36]) begin
                  n_fail++; $display("FAIL rand_ftz%0d: got %b/%h, want %b/%h", got, f_flags, f_result, x[71:68], x[67:36]);
               end
            end
         end
         @(posedge clk); #1;
         if (acc || !in_valid) begin
            if (sent < nbeats && $urandom_range(0, 3) != 0) begin gen_beat(); in_valid = 1'b1; end
            else in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_tests++;
      if (got != nbeats) begin n_fail++; $display("FAIL rand_count: got %0d beats, want %0d", got, nbeats); end
   endtask

   task automatic test_back_to_back();
      int ex[3];
      logic [47:0] mt[3];
      logic [35:0] q[$];
      logic [35:0] x;
      logic [31:0] held;
      int idx, got, k;
      ex[0] = 127; ex[1] = 128; ex[2] = 126;
      mt[0] = 48'h4800_0000_0000; mt[1] = 48'h9000_0000_0000; mt[2] = 48'h4000_0040_0001;
      out_ready = 1'b0; idx = 0; held = '0;
      drive(0, 0, 0, 0, 0, ex[0], mt[0]); in_valid = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         if (in_valid && in_ready) begin
            q.push_back(model(0, 0, 0, 0, 0, ex[idx], mt[idx], 1'b0)); idx++;
         end
         if (cyc == 2) begin
            held = out_result;
            n_tests++;
            if (in_ready !== 1'b0 || idx != 2) begin
               n_fail++; $display("FAIL bp_stall: in_ready=%b accepted=%0d, want 0 and 2", in_ready, idx);
            end
         end
         if (cyc == 3) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_result !== held) begin
               n_fail++; $display("FAIL bp_hold: v=%b r=%h, want 1 and %h", out_valid, out_result, held);
            end
         end
         @(posedge clk); #1;
         if (idx < 3) drive(0, 0, 0, 0, 0, ex[idx], mt[idx]); else in_valid = 1'b0;
      end
      out_ready = 1'b1; got = 0; k = 0;
      while (got < 3 && k < 20) begin
         @(negedge clk); k++;
         if (in_valid && in_ready) begin
            q.push_back(model(0, 0, 0, 0, 0, ex[idx], mt[idx], 1'b0)); idx++;
         end
         if (out_valid) begin
            got++;
            x = (q.size() != 0) ? q.pop_front() : 36'h0;
            n_tests++;
            if ({out_flags, out_result} !== x) begin
               n_fail++; $display("FAIL bp_order%0d: got %b/%h, want %b/%h", got, out_flags, out_result, x[35:32], x[31:0]);
            end
         end
         @(posedge clk); #1;
         if (idx >= 3) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      n_tests++;
      if (got != 3) begin n_fail++; $display("FAIL bp_count: got %0d, want 3", got); end
   endtask

   task automatic test_reset_midstream();
      int seen;
      out_ready = 1'b0;
      drive(0, 0, 0, 0, 0, 127, 48'h4000_0000_0000); in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1; in_valid = 1'b0;
      rst = 1'b1; #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_result !== 32'h0) begin
         n_fail++; $display("FAIL rst_mid: v=%b r=%h, want 0 and 0", out_valid, out_result);
      end
      @(negedge clk); rst = 1'b0; out_ready = 1'b1;
      seen = 0;
      repeat (5) begin @(negedge clk); if (out_valid) seen++; end
      n_tests++;
      if (seen != 0) begin n_fail++; $display("FAIL rst_flush: %0d stale outputs, want 0", seen); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random(300);
      test_back_to_back();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
